// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative MSB-first shift-add multiplier; one partial step per cycle, WIDTH steps.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc, step;
    logic [CW-1:0]      cnt;

    // done/product are combinational so the caller can load on the final step edge
    assign step    = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (b_r[cnt] ? a_r : {WIDTH{1'b0}})};
    assign done    = busy && (cnt == '0);
    assign product = step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            cnt  <= CW'(WIDTH - 1);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= step;
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: registered result/flags, 1-cycle ops, optional WIDTH-cycle multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = $clog2(WIDTH);

    logic [1:0]         state;
    logic               accept, is_mul, mul_start;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum, diff, shl_w, shr_w;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, zero_r;

    assign in_ready  = (state == ST_IDLE) | ((state == ST_FULL) & out_ready);
    assign accept    = in_valid & in_ready;
    assign is_mul    = MUL_EN && (op == OP_MUL);
    assign mul_start = accept & is_mul;
    assign out_valid = (state == ST_FULL);
    assign zero      = zero_r;
    assign neg       = o[WIDTH-1];

    assign sum   = {1'b0, i0} + {1'b0, i1};
    assign diff  = {1'b0, i0} - {1'b0, i1};
    // extra bit on each side catches the last bit shifted out
    assign shl_w = {1'b0, i0} << i1[AW-1:0];
    assign shr_w = {i0, 1'b0} >> i1[AW-1:0];

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (i0[WIDTH-1] == i1[WIDTH-1]) && (sum[WIDTH-1] != i0[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = ~diff[WIDTH];
                res_v = (i0[WIDTH-1] != i1[WIDTH-1]) && (diff[WIDTH-1] != i0[WIDTH-1]);
            end
            OP_AND: res = i0 & i1;
            OP_OR:  res = i0 | i1;
            OP_XOR: res = i0 ^ i1;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                res   = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            default: ;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .a       (i0),
                .b       (i1),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            o      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FULL: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                        end else begin
                            state  <= ST_FULL;
                            o      <= res;
                            cout   <= res_c;
                            ovf    <= res_v;
                            zero_r <= (res == '0);
                        end
                    end else if (state == ST_FULL && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state  <= ST_FULL;
                        o      <= mul_prod[WIDTH-1:0];
                        cout   <= |mul_prod[2*WIDTH-1:WIDTH];
                        ovf    <= 1'b0;
                        zero_r <= (mul_prod[WIDTH-1:0] == '0);
                    end else if (!mul_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized + directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [15:0] i0, i1;
    logic        in_valid, in_ready;
    logic [15:0] o;
    logic        cout, zero, neg, ovf, out_valid, out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .i0        (i0),
        .i1        (i1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic void model(input int opc, input int a, input int b,
                                  output int eo, output int ec, output int ev);
        longint sa, sb, r, p;
        int amt;
        sa = (a > 32767) ? a - 65536 : a;
        sb = (b > 32767) ? b - 65536 : b;
        amt = b & 15;
        eo = 0; ec = 0; ev = 0;
        case (opc)
            0: begin
                eo = (a + b) & 'hffff; ec = (a + b) >> 16;
                r = sa + sb; ev = int'(r > 32767 || r < -32768);
            end
            1: begin
                eo = (a - b) & 'hffff; ec = int'(a >= b);
                r = sa - sb; ev = int'(r > 32767 || r < -32768);
            end
            2: eo = a & b;
            3: eo = a | b;
            4: eo = a ^ b;
            5: begin
                eo = (a << amt) & 'hffff;
                ec = (amt != 0) ? (a >> (16 - amt)) & 1 : 0;
            end
            6: begin
                eo = a >> amt;
                ec = (amt != 0) ? (a >> (amt - 1)) & 1 : 0;
            end
            default: begin
                p = longint'(a) * longint'(b);
                eo = int'(p & 'hffff); ec = int'((p >> 16) != 0);
            end
        endcase
    endfunction

    // one transaction with out_ready=1; latency counted in edges after the accept edge
    task automatic run_op(input int opc, input int a, input int b);
        int eo, ec, ev, cyc;
        bit ir_low;
        model(opc, a, b, eo, ec, ev);
        @(negedge clk);
        op = opc[2:0]; i0 = a[15:0]; i1 = b[15:0]; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk("in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0; ir_low = 1'b1;
        while (!out_valid && cyc < 100) begin
            if (in_ready) ir_low = 1'b0;
            @(negedge clk); cyc++;
        end
        chk("latency", cyc, (opc == 7) ? 16 : 0);
        if (opc == 7) chk("mul_in_ready_low", ir_low, 1);
        chk("o", o, eo);
        chk("cout", cout, ec);
        chk("zero", zero, (eo == 0) ? 1 : 0);
        chk("neg", neg, (eo >> 15) & 1);
        chk("ovf", ovf, ev);
    endtask

    int d_op [9] = '{0, 0, 1, 1, 7, 7, 5, 6, 5};
    int d_a  [9] = '{'haa55, 'hffff, 'h0001, 'h8000, 'h00ff, 'hffff, 'h8001, 'h0001, 'h1234};
    int d_b  [9] = '{'h55aa, 'h0001, 'h7fff, 'h0001, 'h0101, 'h0002, 'h0001, 'h0011, 'h0000};
    int d_o  [9] = '{'hffff, 'h0000, 'h8002, 'h7fff, 'hffff, 'hfffe, 'h0002, 'h0000, 'h1234};
    int d_c  [9] = '{0, 1, 0, 1, 0, 1, 1, 1, 0};
    int d_v  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        int cop, ca, cb, eo, ec, ev;
        bit stayed_low;
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        op = '0; i0 = '0; i1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_o", o, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 0);
        chk("rst_neg", neg, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;

        for (int k = 0; k < 9; k++) begin
            run_op(d_op[k], d_a[k], d_b[k]);
            chk("dir_o", o, d_o[k]);
            chk("dir_cout", cout, d_c[k]);
            chk("dir_ovf", ovf, d_v[k]);
        end

        // backpressure: result held, pending OR taken on the out_ready rising cycle
        @(negedge clk);
        out_ready = 1'b0; op = 3'b010; i0 = 16'haa55; i1 = 16'h55aa; in_valid = 1'b1;
        @(negedge clk);
        op = 3'b011;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_o", o, 0);
            chk("hold_zero", zero, 1);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pend_valid", out_valid, 1);
        chk("pend_o", o, 'hffff);

        // back-to-back single-cycle ops at full throughput
        cop = $urandom_range(0, 6); ca = $urandom_range(0, 65535); cb = $urandom_range(0, 65535);
        op = cop[2:0]; i0 = ca[15:0]; i1 = cb[15:0]; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            model(cop, ca, cb, eo, ec, ev);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_o", o, eo);
            chk("b2b_cout", cout, ec);
            chk("b2b_ovf", ovf, ev);
            if (k < 19) begin
                cop = $urandom_range(0, 6); ca = $urandom_range(0, 65535); cb = $urandom_range(0, 65535);
                op = cop[2:0]; i0 = ca[15:0]; i1 = cb[15:0];
                chk("b2b_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
        end

        for (int k = 0; k < 120; k++) begin
            cop = $urandom_range(0, 7);
            ca = $urandom_range(0, 65535);
            cb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 65535);
            run_op(cop, ca, cb);
        end

        // reset in the middle of a multiply
        @(negedge clk);
        op = 3'b111; i0 = 16'hffff; i1 = 16'h0003; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_o", o, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_in_ready", in_ready, 1);
        stayed_low = 1'b1;
        repeat (20) begin @(negedge clk); if (out_valid) stayed_low = 1'b0; end
        chk("mrst_no_result", stayed_low, 1);
        run_op(0, 'h0001, 'h7fff);
        chk("post_o", o, 'h8000);
        chk("post_ovf", ovf, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 16-bit 2-op combinational ALU.
- Width is generic; op set grows to 8 with shifts and an iterative multiply.
- Results and flags are registered; valid/ready flow control on input and output.
- Sits between the operand-fetch and writeback stages of the datapath.

Parameters:
- WIDTH, 16, operand/result width (>=4).
- MUL_EN, 1, 1 enables the iterative multiplier; 0 makes op 111 return o=0, cout=0 in one cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  3  operation code.
- i0  in  WIDTH  operand A.
- i1  in  WIDTH  operand B.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept.
- o  out  WIDTH  registered result.
- cout  out  1  carry / borrow-free / shift-out / mul-high-nonzero.
- zero  out  1  o == 0.
- neg  out  1  o[WIDTH-1].
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Ops: 000 ADD i0+i1, cout=carry.
- 001 SUB i0-i1, cout=1 iff i0>=i1 unsigned.
- 010 AND, 011 OR, 100 XOR; cout=0 for all three.
- 101 SHL, 110 SHR (logical). Amount = i1[$clog2(WIDTH)-1:0]. cout = last bit shifted out; 0 if amount is 0.
- 111 MUL: o = low WIDTH bits of unsigned product; cout = 1 iff the high WIDTH bits are nonzero.
- Result width is always WIDTH; excess bits are discarded.
- States: IDLE, MUL, FULL.
- in_ready = (state==IDLE) | (state==FULL & out_ready). Combinational, 0 in MUL.
- Accept = in_valid & in_ready at a rising edge. Operands and op are captured at accept; later input changes are ignored.
- Non-MUL accept: o and flags are registered at that edge; state goes to FULL; out_valid=1 next cycle (latency 1, throughput 1 under out_ready=1).
- MUL accept: state goes to MUL. An iterative shift-add runs with a counter WIDTH-1..0, one partial step per cycle. After edge k+WIDTH (accept at edge k), o and flags are loaded, state goes to FULL, out_valid=1.
- FULL: o and all flags are held stable while out_ready=0.
- FULL with out_ready=1 and no accept: go to IDLE, out_valid drops.
- FULL with out_ready=1 and a simultaneous accept: a non-MUL op goes to FULL with the new result; a MUL goes to MUL with out_valid=0.
- out_valid=0 in IDLE and MUL.
- zero/neg are derived from the registered o; ovf is computed at load.
- Reset (async, reset=0): state=IDLE, o=0, cout=zero=neg=ovf=0 (zero forced 0, not derived), out_valid=0, counter=0.
- Reset mid-MUL aborts the multiply with no result. in_ready=1 in the first cycle after reset deasserts.
- MUL_EN=0: op 111 behaves as a single-cycle op, o=0, cout=0, zero=1.

Decomposition:
- alu_pkg: op codes (OP_ADD..OP_MUL), state encoding (ST_IDLE, ST_MUL, ST_FULL).
- Sub-module alu_mul_iter: start/busy/done iterative shift-add multiplier, WIDTH-cycle latency, outputs 2*WIDTH product. Instantiated only when MUL_EN=1 (generate).
- All other op logic and the FSM stay in alu_pipe.

Test Plan:
- (WIDTH=16, out_ready=1) ADD aa55+55aa -> o=ffff, cout=0, neg=1, zero=0, ovf=0, out_valid one cycle after accept. ADD ffff+0001 -> o=0000, cout=1, zero=1.
- SUB 0001-7fff -> o=8002, cout=0, neg=1, ovf=0. SUB 8000-0001 -> o=7fff, cout=1, ovf=1.
- MUL 00ff*0101 -> o=ffff, cout=0, out_valid exactly 16 cycles after accept, in_ready=0 throughout. MUL ffff*0002 -> o=fffe, cout=1.
- out_ready=0: AND aa55&55aa -> o=0000, zero=1 held for 5 cycles, in_ready=0. A pending OR aa55|55aa is accepted on the out_ready rising cycle -> o=ffff next cycle.
- SHL 8001 by 0001 -> o=0002, cout=1. SHR 0001 by 0011 (amount 1) -> o=0000, cout=1, zero=1. SHL x by 0 -> o=x, cout=0.
- Assert reset 5 cycles into a MUL -> out_valid=0, o=0 immediately. After release, in_ready=1 and ADD 0001+7fff -> o=8000, ovf=1.
